// File: rtl/hdmi_period_scheduler.sv
// Video timing generator and TMDS period sequencer: free-running raster counters drive
// sync, preamble, guard band, DE and a one-cycle-ahead pixel fetch request.
module hdmi_period_scheduler #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0
) (
    input  logic        pixelClock,
    input  logic        resetN,
    input  logic        enable,
    input  logic        hdmiMode,
    output logic        DE,
    output logic [1:0]  controlBus0,
    output logic [1:0]  controlBus1,
    output logic [1:0]  controlBus2,
    output logic        guardBand,
    output logic        pixelRequest,
    output logic [10:0] pixelX,
    output logic [9:0]  pixelY,
    output logic        frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST        = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_END     = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEGIN  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END    = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_PRE_BEGIN   = 11'(H_TOTAL - 10);
    localparam logic [10:0] H_GUARD_BEGIN = 11'(H_TOTAL - 2);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT_END    = 10'(V_ACTIVE);
    localparam logic [9:0] V_ACT_LAST   = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_SYNC_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic HS_ON = (HSYNC_POL != 0);
    localparam logic VS_ON = (VSYNC_POL != 0);

    typedef enum logic [1:0] {
        CONTROL,
        PREAMBLE,
        GUARD,
        ACTIVE
    } periodType;

    logic [10:0] hCount, hNext;
    logic [9:0]  vCount, vNext;
    logic        frameEn, frameEnNext;
    logic        hdmiEn, hdmiEnNext;
    logic        latchPoint;
    logic        nextLineActive;
    logic        requestAhead;
    logic        hsyncNow, vsyncNow;
    periodType   period;

    // NOTE: every variable gets a default at the top of the block so no path can
    // leave one unassigned, which would otherwise infer a latch.
    always_comb begin
        hNext          = hCount + 11'd1;
        vNext          = vCount;
        latchPoint     = (hCount == 11'd0) && (vCount == V_LAST);
        frameEnNext    = latchPoint ? enable : frameEn;
        hdmiEnNext     = latchPoint ? hdmiMode : hdmiEn;
        nextLineActive = (vCount == V_LAST) || (vCount < V_ACT_LAST);
        hsyncNow       = (hCount >= H_SYNC_BEGIN) && (hCount < H_SYNC_END);
        vsyncNow       = (vCount >= V_SYNC_BEGIN) && (vCount < V_SYNC_END);
        period         = CONTROL;

        if (hCount == H_LAST) begin
            hNext = 11'd0;
            vNext = (vCount == V_LAST) ? 10'd0 : vCount + 10'd1;
        end

        // Preamble/guard sit in the back porch, so they can never overlap ACTIVE.
        if (frameEn && (vCount < V_ACT_END) && (hCount < H_ACT_END)) begin
            period = ACTIVE;
        end else if (hdmiEn && frameEn && nextLineActive && (hCount >= H_PRE_BEGIN)) begin
            period = (hCount >= H_GUARD_BEGIN) ? GUARD : PREAMBLE;
        end

        // The request is registered from the next raster position, landing one cycle ahead of DE.
        requestAhead = frameEnNext && (vNext < V_ACT_END) && (hNext < H_ACT_END);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            hCount  <= 11'd0;
            vCount  <= V_ACT_END;
            frameEn <= 1'b0;
            hdmiEn  <= 1'b0;
        end else begin
            hCount  <= hNext;
            vCount  <= vNext;
            frameEn <= frameEnNext;
            hdmiEn  <= hdmiEnNext;
        end
    end

    always_ff @(posedge pixelClock or negedge resetN) begin
        if (!resetN) begin
            DE           <= 1'b0;
            guardBand    <= 1'b0;
            controlBus0  <= {~VS_ON, ~HS_ON};
            controlBus1  <= 2'b00;
            pixelRequest <= 1'b0;
            pixelX       <= 11'd0;
            pixelY       <= 10'd0;
            frameStart   <= 1'b0;
        end else begin
            DE           <= (period == ACTIVE);
            guardBand    <= (period == GUARD);
            controlBus0  <= {vsyncNow ? VS_ON : ~VS_ON, hsyncNow ? HS_ON : ~HS_ON};
            controlBus1  <= (period == PREAMBLE) ? 2'b01 : 2'b00;
            pixelRequest <= requestAhead;
            frameStart   <= (hCount == 11'd0) && (vCount == 10'd0);
            if (requestAhead) begin
                pixelX <= hNext;
                pixelY <= vNext;
            end
        end
    end

    // CTL3/CTL2 are zero in every period, including the video preamble.
    assign controlBus2 = 2'b00;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler on a 25x8 raster (H 8/2/3/12, V 4/1/1/2).
// Each captured frame is folded into per-line 25-bit masks indexed by hCount.
`timescale 1ns/1ps
module tb_hdmi_period_scheduler;

    localparam logic [24:0] M_DE       = 25'h00000FF;
    localparam logic [24:0] M_PRE      = 25'h07F8000;
    localparam logic [24:0] M_GUARD    = 25'h1800000;
    localparam logic [24:0] M_HS       = 25'h0001C00;
    localparam logic [24:0] M_ALL      = 25'h1FFFFFF;
    localparam logic [24:0] M_REQ      = 25'h000007F;
    localparam logic [24:0] M_REQ_WRAP = 25'h1000000;

    logic        pixelClock = 1'b0;
    logic        resetN     = 1'b0;
    logic        enable     = 1'b0;
    logic        hdmiMode   = 1'b0;
    logic        DE, guardBand, pixelRequest, frameStart;
    logic [1:0]  controlBus0, controlBus1, controlBus2;
    logic [10:0] pixelX;
    logic [9:0]  pixelY;

    int compared   = 0;
    int mismatched = 0;

    logic [24:0] deM [8];
    logic [24:0] preM [8];
    logic [24:0] guardM [8];
    logic [24:0] hsM [8];
    logic [24:0] vsM [8];
    logic [24:0] reqM [8];
    logic        capReq [200];
    logic [10:0] capX [200];
    logic [9:0]  capY [200];
    int          fsCount;
    int          ctlBad;

    always #5 pixelClock = ~pixelClock;

    hdmi_period_scheduler #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(12),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) dut (
        .pixelClock  (pixelClock),
        .resetN      (resetN),
        .enable      (enable),
        .hdmiMode    (hdmiMode),
        .DE          (DE),
        .controlBus0 (controlBus0),
        .controlBus1 (controlBus1),
        .controlBus2 (controlBus2),
        .guardBand   (guardBand),
        .pixelRequest(pixelRequest),
        .pixelX      (pixelX),
        .pixelY      (pixelY),
        .frameStart  (frameStart)
    );

    function automatic logic [24:0] expDe(int l, logic en);
        return (en && l < 4) ? M_DE : 25'h0;
    endfunction

    // curOn/nextOn: video and HDMI both latched for the current/next frame.
    function automatic logic hasPre(int l, logic curOn, logic nextOn);
        return (curOn && l < 3) || (nextOn && l == 7);
    endfunction

    function automatic logic [24:0] expReq(int l, logic curEn, logic nextEn);
        return ((curEn && l < 4) ? M_REQ : 25'h0) |
               (((curEn && l < 3) || (nextEn && l == 7)) ? M_REQ_WRAP : 25'h0);
    endfunction

    // Capture the 200 output cycles starting at the next frameStart sample.
    task automatic captureFrame(input int toggleAt, input logic toggleVal);
        int waited = 0;
        int l, h;
        fsCount = 0;
        ctlBad  = 0;
        for (int i = 0; i < 8; i++) begin
            deM[i] = '0; preM[i] = '0; guardM[i] = '0;
            hsM[i] = '0; vsM[i] = '0; reqM[i] = '0;
        end
        while (frameStart !== 1'b1 && waited < 400) begin
            @(negedge pixelClock);
            waited++;
        end
        compared++;
        if (waited >= 400) begin
            mismatched++;
            $display("FAIL frame_start_timeout: got no frameStart in %0d cycles, want one within 400", waited);
        end
        for (int j = 0; j < 200; j++) begin
            if (j > 0) @(negedge pixelClock);
            l = j / 25;
            h = j % 25;
            deM[l][h]    = (DE === 1'b1);
            preM[l][h]   = (controlBus1 === 2'b01);
            guardM[l][h] = (guardBand === 1'b1);
            hsM[l][h]    = (controlBus0[0] === 1'b1);
            vsM[l][h]    = (controlBus0[1] === 1'b1);
            reqM[l][h]   = (pixelRequest === 1'b1);
            capReq[j]    = (pixelRequest === 1'b1);
            capX[j]      = pixelX;
            capY[j]      = pixelY;
            if (frameStart === 1'b1) fsCount++;
            if (controlBus2 !== 2'b00 || (controlBus1 !== 2'b00 && controlBus1 !== 2'b01)) ctlBad++;
            if (j == toggleAt) enable = toggleVal;
        end
    endtask

    task automatic test_reset();
        int k = 0;
        enable   = 1'b1;
        hdmiMode = 1'b1;
        resetN   = 1'b0;
        #23;
        compared++;
        if ({DE, guardBand, pixelRequest, frameStart, controlBus0, controlBus1, controlBus2, pixelX, pixelY} !== 31'h0) begin
            mismatched++;
            $display("FAIL reset_outputs: got DE=%b gb=%b req=%b fs=%b cb0=%b cb1=%b cb2=%b x=%0d y=%0d, want all zero",
                     DE, guardBand, pixelRequest, frameStart, controlBus0, controlBus1, controlBus2, pixelX, pixelY);
        end
        @(negedge pixelClock);
        resetN = 1'b1;
        do begin
            @(negedge pixelClock);
            k++;
        end while (frameStart !== 1'b1 && k < 400);
        compared++;
        if (k != 101) begin
            mismatched++;
            $display("FAIL reset_first_frame: got frameStart at cycle %0d, want 101", k);
        end
    endtask

    task automatic test_hdmi_video();
        for (int f = 0; f < 2; f++) begin
            captureFrame(-1, 1'b0);
            for (int l = 0; l < 8; l++) begin
                compared += 6;
                if (deM[l] !== expDe(l, 1'b1)) begin
                    mismatched++; $display("FAIL hdmi_de line %0d: got %h want %h", l, deM[l], expDe(l, 1'b1));
                end
                if (preM[l] !== (hasPre(l, 1'b1, 1'b1) ? M_PRE : 25'h0)) begin
                    mismatched++; $display("FAIL hdmi_preamble line %0d: got %h", l, preM[l]);
                end
                if (guardM[l] !== (hasPre(l, 1'b1, 1'b1) ? M_GUARD : 25'h0)) begin
                    mismatched++; $display("FAIL hdmi_guard line %0d: got %h", l, guardM[l]);
                end
                if (hsM[l] !== M_HS) begin
                    mismatched++; $display("FAIL hdmi_hsync line %0d: got %h want %h", l, hsM[l], M_HS);
                end
                if (vsM[l] !== ((l == 5) ? M_ALL : 25'h0)) begin
                    mismatched++; $display("FAIL hdmi_vsync line %0d: got %h", l, vsM[l]);
                end
                if (reqM[l] !== expReq(l, 1'b1, 1'b1)) begin
                    mismatched++; $display("FAIL hdmi_request line %0d: got %h want %h", l, reqM[l], expReq(l, 1'b1, 1'b1));
                end
            end
            compared += 2;
            if (fsCount != 1) begin
                mismatched++; $display("FAIL hdmi_frame_start_count: got %0d want 1", fsCount);
            end
            if (ctlBad != 0) begin
                mismatched++; $display("FAIL hdmi_ctl_values: got %0d illegal cycles want 0", ctlBad);
            end
        end
    endtask

    task automatic test_dvi_mode();
        hdmiMode = 1'b0;
        // This frame was latched as HDMI; only the next frame's line-0 preamble disappears.
        captureFrame(-1, 1'b0);
        for (int l = 0; l < 8; l++) begin
            compared++;
            if (preM[l] !== ((l < 3) ? M_PRE : 25'h0)) begin
                mismatched++; $display("FAIL dvi_switch_preamble line %0d: got %h", l, preM[l]);
            end
        end
        captureFrame(-1, 1'b0);
        for (int l = 0; l < 8; l++) begin
            compared += 5;
            if (preM[l] !== 25'h0) begin
                mismatched++; $display("FAIL dvi_preamble line %0d: got %h want 0", l, preM[l]);
            end
            if (guardM[l] !== 25'h0) begin
                mismatched++; $display("FAIL dvi_guard line %0d: got %h want 0", l, guardM[l]);
            end
            if (deM[l] !== expDe(l, 1'b1)) begin
                mismatched++; $display("FAIL dvi_de line %0d: got %h want %h", l, deM[l], expDe(l, 1'b1));
            end
            if (hsM[l] !== M_HS) begin
                mismatched++; $display("FAIL dvi_hsync line %0d: got %h want %h", l, hsM[l], M_HS);
            end
            if (vsM[l] !== ((l == 5) ? M_ALL : 25'h0)) begin
                mismatched++; $display("FAIL dvi_vsync line %0d: got %h", l, vsM[l]);
            end
        end
        compared++;
        if (ctlBad != 0) begin
            mismatched++; $display("FAIL dvi_ctl_values: got %0d illegal cycles want 0", ctlBad);
        end
    endtask

    task automatic test_disabled();
        int k = 0;
        enable   = 1'b0;
        hdmiMode = 1'b1;
        captureFrame(-1, 1'b0);
        captureFrame(-1, 1'b0);
        for (int l = 0; l < 8; l++) begin
            compared += 6;
            if (deM[l] !== 25'h0) begin
                mismatched++; $display("FAIL off_de line %0d: got %h want 0", l, deM[l]);
            end
            if (reqM[l] !== 25'h0) begin
                mismatched++; $display("FAIL off_request line %0d: got %h want 0", l, reqM[l]);
            end
            if (guardM[l] !== 25'h0) begin
                mismatched++; $display("FAIL off_guard line %0d: got %h want 0", l, guardM[l]);
            end
            if (preM[l] !== 25'h0) begin
                mismatched++; $display("FAIL off_preamble line %0d: got %h want 0", l, preM[l]);
            end
            if (hsM[l] !== M_HS) begin
                mismatched++; $display("FAIL off_hsync line %0d: got %h want %h", l, hsM[l], M_HS);
            end
            if (vsM[l] !== ((l == 5) ? M_ALL : 25'h0)) begin
                mismatched++; $display("FAIL off_vsync line %0d: got %h", l, vsM[l]);
            end
        end
        compared++;
        if (fsCount != 1) begin
            mismatched++; $display("FAIL off_frame_start_count: got %0d want 1", fsCount);
        end
        // Measure the distance between two consecutive frameStart pulses.
        while (frameStart !== 1'b1 && k < 400) begin
            @(negedge pixelClock);
            k++;
        end
        k = 0;
        do begin
            @(negedge pixelClock);
            k++;
        end while (frameStart !== 1'b1 && k < 400);
        compared++;
        if (k != 200) begin
            mismatched++; $display("FAIL off_frame_period: got %0d want 200", k);
        end
    endtask

    task automatic test_enable_toggle();
        // Frame A: dark, enable rises on line 2 -> only the next frame's line-0 preamble shows.
        captureFrame(50, 1'b1);
        for (int l = 0; l < 8; l++) begin
            compared += 3;
            if (deM[l] !== 25'h0) begin
                mismatched++; $display("FAIL toggle_on_de line %0d: got %h want 0", l, deM[l]);
            end
            if (preM[l] !== ((l == 7) ? M_PRE : 25'h0) || guardM[l] !== ((l == 7) ? M_GUARD : 25'h0)) begin
                mismatched++; $display("FAIL toggle_on_preamble line %0d: got pre %h guard %h", l, preM[l], guardM[l]);
            end
            if (reqM[l] !== expReq(l, 1'b0, 1'b1)) begin
                mismatched++; $display("FAIL toggle_on_request line %0d: got %h want %h", l, reqM[l], expReq(l, 1'b0, 1'b1));
            end
        end
        // Frame B: full video, enable falls on line 2 -> frame completes, no line-0 preamble after it.
        captureFrame(50, 1'b0);
        for (int l = 0; l < 8; l++) begin
            compared += 3;
            if (deM[l] !== expDe(l, 1'b1)) begin
                mismatched++; $display("FAIL toggle_off_de line %0d: got %h want %h", l, deM[l], expDe(l, 1'b1));
            end
            if (preM[l] !== ((l < 3) ? M_PRE : 25'h0) || guardM[l] !== ((l < 3) ? M_GUARD : 25'h0)) begin
                mismatched++; $display("FAIL toggle_off_preamble line %0d: got pre %h guard %h", l, preM[l], guardM[l]);
            end
            if (reqM[l] !== expReq(l, 1'b1, 1'b0)) begin
                mismatched++; $display("FAIL toggle_off_request line %0d: got %h want %h", l, reqM[l], expReq(l, 1'b1, 1'b0));
            end
        end
        captureFrame(-1, 1'b0);
        for (int l = 0; l < 8; l++) begin
            compared++;
            if ((deM[l] | reqM[l] | preM[l]) !== 25'h0) begin
                mismatched++; $display("FAIL toggle_dark line %0d: got de %h req %h pre %h want 0", l, deM[l], reqM[l], preM[l]);
            end
        end
    endtask

    task automatic test_pixel_coords();
        int reqCount = 0;
        int ex, ey;
        enable = 1'b1;
        captureFrame(-1, 1'b0);
        captureFrame(-1, 1'b0);
        for (int j = 0; j < 200; j++) begin
            if (capReq[j]) begin
                reqCount++;
                ex = (j + 1) % 25;
                ey = ((j + 1) / 25) % 8;
                compared++;
                if (capX[j] !== 11'(ex) || capY[j] !== 10'(ey)) begin
                    mismatched++; $display("FAIL pixel_coord at %0d: got (%0d,%0d) want (%0d,%0d)", j, capX[j], capY[j], ex, ey);
                end
            end
        end
        compared += 4;
        if (reqCount != 32) begin
            mismatched++; $display("FAIL pixel_request_count: got %0d want 32", reqCount);
        end
        if (!capReq[199] || capX[199] !== 11'd0 || capY[199] !== 10'd0) begin
            mismatched++; $display("FAIL pixel_first: got req=%b (%0d,%0d) want 1 (0,0)", capReq[199], capX[199], capY[199]);
        end
        if (!capReq[81] || capX[81] !== 11'd7 || capY[81] !== 10'd3) begin
            mismatched++; $display("FAIL pixel_last: got req=%b (%0d,%0d) want 1 (7,3)", capReq[81], capX[81], capY[81]);
        end
        if (capReq[150] || capX[150] !== 11'd7 || capY[150] !== 10'd3) begin
            mismatched++; $display("FAIL pixel_hold: got req=%b (%0d,%0d) want 0 (7,3)", capReq[150], capX[150], capY[150]);
        end
    endtask

    task automatic test_reset_mid_preamble();
        int k = 0;
        int vsFirst = 0;
        while (frameStart !== 1'b1 && k < 400) begin
            @(negedge pixelClock);
            k++;
        end
        repeat (192) @(negedge pixelClock);
        compared++;
        if (controlBus1 !== 2'b01) begin
            mismatched++; $display("FAIL midreset_in_preamble: got cb1=%b want 01", controlBus1);
        end
        #2 resetN = 1'b0;
        #1;
        compared++;
        if ({DE, guardBand, pixelRequest, frameStart, controlBus0, controlBus1, controlBus2, pixelX, pixelY} !== 31'h0) begin
            mismatched++;
            $display("FAIL midreset_outputs: got DE=%b gb=%b req=%b fs=%b cb0=%b cb1=%b x=%0d y=%0d, want all zero",
                     DE, guardBand, pixelRequest, frameStart, controlBus0, controlBus1, pixelX, pixelY);
        end
        @(negedge pixelClock);
        resetN = 1'b1;
        k = 0;
        do begin
            @(negedge pixelClock);
            k++;
            if (vsFirst == 0 && controlBus0[1] === 1'b1) vsFirst = k;
        end while (frameStart !== 1'b1 && k < 400);
        compared += 2;
        if (k != 101) begin
            mismatched++; $display("FAIL midreset_restart_frame: got frameStart at cycle %0d, want 101", k);
        end
        if (vsFirst != 26) begin
            mismatched++; $display("FAIL midreset_restart_vsync: got VSYNC first at cycle %0d, want 26", vsFirst);
        end
    endtask

    initial begin
        test_reset();
        test_hdmi_video();
        test_dvi_mode();
        test_disabled();
        test_enable_toggle();
        test_pixel_coords();
        test_reset_mid_preamble();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
